// File: rtl/p_if_prefetch_pkg.sv
// Shared definitions for the prefetching instruction-fetch stage.
//   if_state_t   : fetch FSM states (IF_IDLE waits for a free slot, IF_WAIT
//                  holds a request until the memory controller completes it)
//   INST_LEN     : bytes per instruction fetch, driven on len_in_byte
//   INST_PORT_ID : default identifier of the instruction port on the
//                  memory controller
package p_if_prefetch_pkg;

    typedef enum logic {
        IF_IDLE = 1'b0,
        IF_WAIT = 1'b1
    } if_state_t;

    localparam logic [2:0] INST_LEN     = 3'd4;
    localparam logic [1:0] INST_PORT_ID = 2'b01;

endpackage

// File: rtl/p_if_prefetch_inst_fifo.sv
// Parametrised synchronous FIFO holding {instruction, pc} pairs.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata at the tail (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   flush    : empty the FIFO; overrides push and pop in the same cycle
//   wdata    : entry to write
//   rdata    : current head entry, valid whenever empty=0
//   count    : number of stored entries, 0..DEPTH
//   empty    : count == 0
//   full     : count == DEPTH
// The head is read straight out of the storage array so a word written at
// one edge is at the head in the very next cycle; this keeps the storage in
// distributed memory rather than a registered-read block RAM.
module if_inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_C);
    assign count   = count_reg;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr_reg];

    // Storage carries no reset; the empty flag guards every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers are log2(DEPTH) bits wide and wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/p_if_prefetch.sv
// Prefetching instruction-fetch stage between the memory controller's
// instruction port and decode. Runs ahead sequentially, buffering up to
// QUEUE_DEPTH fetched words, and flushes on branch redirects.
//   clk_in, rst_in  : clock, asynchronous active-high reset
//   rdy_in          : global ready; low freezes every register
//   jump, next_addr : redirect pulse and 4-byte aligned target
//   re, fetch_addr  : fetch request and address to the memory controller
//   len_in_byte     : constant 4; port_id : constant PORT_ID
//   inst_in         : fetched word, valid with mem_done
//   mem_busy        : controller serving another port (response not ours)
//   mem_done        : one-cycle completion pulse for this port
//   mem_stall       : pipeline stall; freezes every register
//   inst_valid, inst_ready, inst, inst_pc : head of queue handshake to decode
//   busy_out        : inverse of inst_valid
module p_if_prefetch
    import p_if_prefetch_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter logic [1:0]       PORT_ID     = INST_PORT_ID
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            jump,
    input  logic [XLEN-1:0] next_addr,
    output logic            re,
    output logic [XLEN-1:0] fetch_addr,
    output logic [2:0]      len_in_byte,
    output logic [1:0]      port_id,
    input  logic [XLEN-1:0] inst_in,
    input  logic            mem_busy,
    input  logic            mem_done,
    input  logic            mem_stall,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            busy_out
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] INST_STEP = XLEN'(INST_LEN);

    if_state_t         state_reg;
    logic [XLEN-1:0]   fetch_pc_reg;
    logic              discard_reg;

    logic              active;
    logic              resp;
    logic              can_issue;
    logic              q_push;
    logic              q_pop;
    logic              q_flush;
    logic [2*XLEN-1:0] q_rdata;
    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic              q_full;

    assign active    = rdy_in && !mem_stall;
    // A response only completes our request when the controller is not
    // simultaneously busy with another port.
    assign resp      = (state_reg == IF_WAIT) && mem_done && !mem_busy;
    // Issue only while a slot is free: with one request outstanding at most,
    // the slot is still free when the response comes back.
    assign can_issue = (q_count < DEPTH_C);

    assign q_flush = active && jump;
    assign q_push  = active && resp && !discard_reg && !jump && !q_full;
    assign q_pop   = active && inst_valid && inst_ready;

    if_inst_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .wdata ({inst_in, fetch_addr}),
        .rdata (q_rdata),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    assign inst_valid  = !q_empty;
    assign busy_out    = q_empty;
    // Present zero on an empty queue so decode never sees stale storage.
    assign inst        = q_empty ? '0 : q_rdata[2*XLEN-1:XLEN];
    assign inst_pc     = q_empty ? '0 : q_rdata[XLEN-1:0];
    assign len_in_byte = INST_LEN;
    assign port_id     = PORT_ID;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg    <= IF_IDLE;
            re           <= 1'b0;
            fetch_addr   <= '0;
            fetch_pc_reg <= RESET_PC;
            discard_reg  <= 1'b0;
        end else if (active) begin
            case (state_reg)
                IF_IDLE: begin
                    // A redirect in IDLE delays the issue by one cycle so the
                    // new target is in fetch_pc_reg when the request goes out.
                    if (!jump && can_issue) begin
                        state_reg  <= IF_WAIT;
                        re         <= 1'b1;
                        fetch_addr <= fetch_pc_reg;
                    end
                end
                IF_WAIT: begin
                    if (resp) begin
                        re          <= 1'b0;
                        state_reg   <= IF_IDLE;
                        discard_reg <= 1'b0;
                        if (!discard_reg && !jump) begin
                            fetch_pc_reg <= fetch_pc_reg + INST_STEP;
                        end
                    end else if (jump) begin
                        // Request already on the bus: let it finish and
                        // throw away its data.
                        discard_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IF_IDLE;
                    re        <= 1'b0;
                end
            endcase
            if (jump) begin
                fetch_pc_reg <= next_addr;
            end
        end
    end

endmodule

// File: tb/tb_p_if_prefetch.sv
module tb_p_if_prefetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        jump;
    logic [31:0] next_addr;
    logic        re;
    logic [31:0] fetch_addr;
    logic [2:0]  len_in_byte;
    logic [1:0]  port_id;
    logic [31:0] inst_in;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_stall;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        busy_out;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    p_if_prefetch #(
        .XLEN        (32),
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0),
        .PORT_ID     (2'b01)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .jump        (jump),
        .next_addr   (next_addr),
        .re          (re),
        .fetch_addr  (fetch_addr),
        .len_in_byte (len_in_byte),
        .port_id     (port_id),
        .inst_in     (inst_in),
        .mem_busy    (mem_busy),
        .mem_done    (mem_done),
        .mem_stall   (mem_stall),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .busy_out    (busy_out)
    );

    typedef struct {
        logic        jump;
        logic [31:0] next_addr;
        logic        done;
        logic        mbusy;
        logic [31:0] din;
        logic        stall;
        logic        rdy;
        logic        ready;
        logic        exp_re;
        logic [31:0] exp_fa;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic j, input logic [31:0] na, input logic d,
                       input logic mb, input logic [31:0] di, input logic st,
                       input logic rd, input logic ir, input logic ere,
                       input logic [31:0] efa, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.jump = j; v.next_addr = na; v.done = d; v.mbusy = mb; v.din = di;
        v.stall = st; v.rdy = rd; v.ready = ir; v.exp_re = ere; v.exp_fa = efa;
        v.exp_valid = ev; v.exp_inst = ei; v.exp_pc = ep;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, want);
        end
    endtask

    task automatic check_outputs(input int idx, input logic ere, input logic [31:0] efa,
                                 input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        check("re", idx, {31'd0, re}, {31'd0, ere});
        check("fetch_addr", idx, fetch_addr, efa);
        check("inst_valid", idx, {31'd0, inst_valid}, {31'd0, ev});
        check("busy_out", idx, {31'd0, busy_out}, {31'd0, ~ev});
        check("inst", idx, inst, ei);
        check("inst_pc", idx, inst_pc, ep);
    endtask

    task automatic idle_inputs();
        jump = 1'b0; next_addr = '0; mem_done = 1'b0; mem_busy = 1'b0;
        inst_in = '0; mem_stall = 1'b0; rdy_in = 1'b1; inst_ready = 1'b1;
    endtask

    localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001;
    localparam logic [31:0] A2 = 32'hA000_0002, A3 = 32'hA000_0003;
    localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB000_0001;
    localparam logic [31:0] B2 = 32'hB000_0002, B3 = 32'hB000_0003;
    localparam logic [31:0] C0 = 32'hC000_0000, C1 = 32'hC000_0001;
    localparam logic [31:0] D0 = 32'hD000_0000, D1 = 32'hD000_0001;
    localparam logic [31:0] D2 = 32'hD000_0002, E0 = 32'hE000_0000;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0, DEAD = 32'h0000_DEAD;
    localparam logic [31:0] TOP = 32'hFFFF_FFFC;

    initial begin
        // jump naddr done mbusy din stall rdy ready | re fa valid inst pc
        // Sequential fetch, mem_done every second cycle, decode always ready
        add(0, 0, 0, 0, 0,  0, 1, 1,  1, 32'h00, 0, 0,  0);
        add(0, 0, 1, 0, A0, 0, 1, 1,  0, 32'h00, 1, A0, 32'h00);
        add(0, 0, 0, 0, 0,  0, 1, 1,  1, 32'h04, 0, 0,  0);
        add(0, 0, 1, 0, A1, 0, 1, 1,  0, 32'h04, 1, A1, 32'h04);
        add(0, 0, 0, 0, 0,  0, 1, 1,  1, 32'h08, 0, 0,  0);
        add(0, 0, 1, 0, A2, 0, 1, 1,  0, 32'h08, 1, A2, 32'h08);
        add(0, 0, 0, 0, 0,  0, 1, 1,  1, 32'h0C, 0, 0,  0);
        add(0, 0, 1, 0, A3, 0, 1, 1,  0, 32'h0C, 1, A3, 32'h0C);
        // Decode stalled: queue fills to 4 and issue stops
        add(0, 0, 0, 0, 0,  0, 1, 0,  1, 32'h10, 1, A3, 32'h0C);
        add(0, 0, 1, 0, B0, 0, 1, 0,  0, 32'h10, 1, A3, 32'h0C);
        add(0, 0, 0, 0, 0,  0, 1, 0,  1, 32'h14, 1, A3, 32'h0C);
        add(0, 0, 1, 0, B1, 0, 1, 0,  0, 32'h14, 1, A3, 32'h0C);
        add(0, 0, 0, 0, 0,  0, 1, 0,  1, 32'h18, 1, A3, 32'h0C);
        add(0, 0, 1, 0, B2, 0, 1, 0,  0, 32'h18, 1, A3, 32'h0C);
        add(0, 0, 0, 0, 0,  0, 1, 0,  0, 32'h18, 1, A3, 32'h0C);
        add(0, 0, 0, 0, 0,  0, 1, 0,  0, 32'h18, 1, A3, 32'h0C);
        add(0, 0, 0, 0, 0,  0, 1, 1,  0, 32'h18, 1, B0, 32'h10);
        add(0, 0, 0, 0, 0,  0, 1, 0,  1, 32'h1C, 1, B0, 32'h10);
        add(0, 0, 1, 0, B3, 0, 1, 0,  0, 32'h1C, 1, B0, 32'h10);
        add(0, 0, 0, 0, 0,  0, 1, 0,  0, 32'h1C, 1, B0, 32'h10);
        add(0, 0, 0, 0, 0,  0, 1, 1,  0, 32'h1C, 1, B1, 32'h14);
        add(0, 0, 0, 0, 0,  0, 1, 0,  1, 32'h20, 1, B1, 32'h14);
        // Redirect while a request is outstanding: late response discarded
        add(1, 32'h100, 0, 0, 0, 0, 1, 0,  1, 32'h20, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0, 1, 0,  1, 32'h20, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0, 1, 0,  1, 32'h20, 0, 0, 0);
        add(0, 0, 1, 0, DEAD, 0, 1, 0,  0, 32'h20, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0, 1, 1,  1, 32'h100, 0, 0, 0);
        add(0, 0, 1, 0, C0,   0, 1, 1,  0, 32'h100, 1, C0, 32'h100);
        // Redirect coinciding with mem_done and a pop
        add(0, 0, 0, 0, 0,  0, 1, 0,  1, 32'h104, 1, C0, 32'h100);
        add(1, 32'h200, 1, 0, C1, 0, 1, 1,  0, 32'h104, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, 1,  1, 32'h200, 0, 0, 0);
        add(0, 0, 1, 0, D0, 0, 1, 1,  0, 32'h200, 1, D0, 32'h200);
        // Freeze by mem_stall and by rdy_in=0: done, jump and pop ignored
        add(0, 0, 0, 0, 0,   0, 1, 0,  1, 32'h204, 1, D0, 32'h200);
        add(0, 0, 1, 0, BAD, 1, 1, 1,  1, 32'h204, 1, D0, 32'h200);
        add(1, 32'h500, 0, 0, 0, 1, 1, 1,  1, 32'h204, 1, D0, 32'h200);
        add(0, 0, 1, 0, BAD, 1, 1, 1,  1, 32'h204, 1, D0, 32'h200);
        add(0, 0, 1, 0, BAD, 0, 0, 1,  1, 32'h204, 1, D0, 32'h200);
        add(1, 32'h600, 0, 0, 0, 0, 0, 1,  1, 32'h204, 1, D0, 32'h200);
        add(0, 0, 1, 0, D1, 0, 1, 0,  0, 32'h204, 1, D0, 32'h200);
        add(0, 0, 0, 0, 0,  0, 1, 1,  1, 32'h208, 1, D1, 32'h204);
        add(0, 0, 1, 0, D2, 0, 1, 1,  0, 32'h208, 1, D2, 32'h208);
        // Address wrap at the top of memory, and mem_busy holds completion
        add(1, TOP, 0, 0, 0, 0, 1, 0,  0, 32'h208, 0, 0, 0);
        add(0, 0, 0, 0, 0,   0, 1, 0,  1, TOP, 0, 0, 0);
        add(0, 0, 1, 0, E0,  0, 1, 0,  0, TOP, 1, E0, TOP);
        add(0, 0, 0, 0, 0,   0, 1, 0,  1, 32'h0, 1, E0, TOP);
        add(0, 0, 1, 1, BAD, 0, 1, 0,  1, 32'h0, 1, E0, TOP);

        idle_inputs();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check_outputs(-1, 0, 32'h0, 0, 0, 0);
        check("len_in_byte", -1, {29'd0, len_in_byte}, 32'd4);
        check("port_id", -1, {30'd0, port_id}, 32'd1);
        rst_in = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            jump = vecs[i].jump; next_addr = vecs[i].next_addr;
            mem_done = vecs[i].done; mem_busy = vecs[i].mbusy;
            inst_in = vecs[i].din; mem_stall = vecs[i].stall;
            rdy_in = vecs[i].rdy; inst_ready = vecs[i].ready;
            @(posedge clk_in);
            #1;
            check_outputs(i, vecs[i].exp_re, vecs[i].exp_fa, vecs[i].exp_valid,
                          vecs[i].exp_inst, vecs[i].exp_pc);
            $display("step %0d: re=%0b fetch_addr=%h inst_valid=%0b inst=%h inst_pc=%h",
                     i, re, fetch_addr, inst_valid, inst, inst_pc);
        end

        // Asynchronous reset while a request is outstanding: outputs drop
        // without waiting for a clock edge.
        idle_inputs();
        inst_ready = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        check_outputs(100, 0, 32'h0, 0, 0, 0);
        $display("async reset: re=%0b inst_valid=%0b busy_out=%0b", re, inst_valid, busy_out);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        check_outputs(101, 1, 32'h0, 0, 0, 0);
        $display("after reset: re=%0b fetch_addr=%h", re, fetch_addr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/p_if_prefetch.md
Name: p_if_prefetch

Overview:
- Parametrised successor to the single-shot instruction fetch stage.
- Keeps a QUEUE_DEPTH-entry prefetch queue filled through the memory-controller fetch port, so decode can consume one instruction per cycle while fetch runs ahead sequentially.
- Handles branch redirects by flushing the queue and discarding any in-flight response.
- Sits between the memory controller (instruction port) and the decode stage.

Parameters:
- XLEN, 32, instruction/address width.
- QUEUE_DEPTH, 4, prefetch entries; power of two, legal range 2..16.
- RESET_PC, 32'h0, first fetch address after reset.
- PORT_ID, 2'b01, value driven on port_id.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global ready; low freezes all state
- jump  in  1  redirect request from execute (single-cycle pulse)
- next_addr  in  XLEN  redirect target; 4-byte aligned
- re  out  1  fetch request to memory controller
- fetch_addr  out  XLEN  fetch address
- len_in_byte  out  3  constant 4
- port_id  out  2  constant PORT_ID
- inst_in  in  XLEN  fetched word; valid when mem_done=1
- mem_busy  in  1  controller serving another port
- mem_done  in  1  one-cycle completion pulse for this port
- mem_stall  in  1  pipeline stall; freezes all state
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst  out  XLEN  head instruction
- inst_pc  out  XLEN  head PC
- busy_out  out  1  queue empty (inst_valid inverted), kept for pipeline control compatibility

Behaviour:
- Reset is asynchronous. Reset values: re=0, fetch_addr=0, inst=0, inst_pc=0, inst_valid=0, busy_out=1; queue count=0; fetch_pc=RESET_PC; FSM=IDLE; discard=0.
- Freeze: when mem_stall=1 or rdy_in=0, no register changes and outputs hold. jump is ignored in a frozen cycle, so execute must hold jump until unfrozen.
- FSM IDLE: when count+0 < QUEUE_DEPTH, go to WAIT and drive re=1, fetch_addr=fetch_pc on the next cycle.
- FSM WAIT: hold re and fetch_addr stable while mem_busy=1 or mem_done=0.
- WAIT, mem_done=1 and discard=0:
  - push {inst_in, fetch_addr};
  - fetch_pc += 4, wrapping mod 2^XLEN;
  - deassert re;
  - return to IDLE; back-to-back issue is allowed the next cycle.
- WAIT, mem_done=1 and discard=1: drop data, clear discard, return to IDLE.
- Issue gate: a request issues only if count < QUEUE_DEPTH, so one slot is always reserved for the outstanding response and a push never overflows.
- Pop: occurs when inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged.
- Latency: a word pushed at the mem_done edge becomes visible at the head (inst_valid=1) in the following cycle. There is no bypass.
- jump=1:
  - flush the queue (count=0, pointers=0) and set fetch_pc=next_addr;
  - if in WAIT and mem_done=0: set discard=1 and stay in WAIT;
  - if in WAIT and mem_done=1 in the same cycle: drop the response and go to IDLE;
  - if in IDLE: stay in IDLE; the new fetch issues the next cycle;
  - a pop in the same cycle has no effect (flush wins).
- A second jump while discard=1 only updates fetch_pc.
- Queue: circular buffer with log2(QUEUE_DEPTH)-bit pointers that wrap naturally. count is log2(QUEUE_DEPTH)+1 bits wide.
- Reset mid-request: drop all state immediately. The memory controller must tolerate re falling without a mem_done.

Decomposition:
- Shared defines/package: FSM state encodings (IF_IDLE, IF_WAIT), instruction length constant 4, instruction port ID constant.
- One natural sub-module: if_inst_fifo, a parametrised sync FIFO with depth, data width XLEN*2, push/pop/flush, count, empty, full.

Test Plan:
1. Reset, then mem_done every 2nd cycle, inst_ready=1 → fetch_addr sequence 0,4,8,12. inst_pc matches inst_addr and inst matches inst_in in order; inst_valid rises 1 cycle after the first mem_done.
2. inst_ready=0, QUEUE_DEPTH=4 → exactly 4 words queued, then re stays 0. Raise inst_ready for 1 cycle → one new request issues.
3. jump to 0x100 while re=1 and mem_done=0; mem_done arrives 3 cycles later with 0xDEAD → 0xDEAD is discarded, next re has fetch_addr 0x100, queue is empty meanwhile.
4. jump to 0x200 in the same cycle as mem_done and pop → queue is empty the next cycle, next request is 0x200, no stale inst_valid.
5. mem_stall=1 for 5 cycles with mem_done pulsed during the stall → no push, all outputs unchanged. Resume → operation continues.
6. fetch_pc=0xFFFFFFFC completes → next fetch_addr=0x00000000. Assert rst_in mid-WAIT → re=0, inst_valid=0 immediately.
